// File: rtl/color_batch_pkg.sv
// Shared definitions for the colour-batch path: colour width, default batch
// size, the unpacker state type and the batch word width helper.
package color_batch_pkg;

    localparam int unsigned COLOR_W            = 8;
    localparam int unsigned DEFAULT_BATCH_SIZE = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int unsigned batch_w(input int unsigned n);
        return n * COLOR_W;
    endfunction

endpackage

// File: rtl/batch_slot_queue.sv
// Two-entry active/pending batch store. A pop retires the active batch; a push
// in the same cycle refills behind it, so a concurrent push never drops.
module batch_slot_queue
    import color_batch_pkg::*;
#(
    parameter int unsigned BATCH_SIZE = DEFAULT_BATCH_SIZE
) (
    input  logic                             I_rgb_clk,
    input  logic                             I_rst_n,
    input  logic                             push,
    input  logic [batch_w(BATCH_SIZE)-1:0]   push_data,
    input  logic                             pop,
    output logic [batch_w(BATCH_SIZE)-1:0]   active_data,
    output logic                             active_v,
    output logic                             pending_v,
    output logic                             drop
);

    logic [batch_w(BATCH_SIZE)-1:0] pending_data;

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            active_data  <= '0;
            pending_data <= '0;
            active_v     <= 1'b0;
            pending_v    <= 1'b0;
        end else if (pop) begin
            if (pending_v) begin
                active_data <= pending_data;
                if (push)
                    pending_data <= push_data;
                else
                    pending_v <= 1'b0;
            end else if (push) begin
                active_data <= push_data;
            end else begin
                active_v <= 1'b0;
            end
        end else if (push) begin
            if (!active_v) begin
                active_data <= push_data;
                active_v    <= 1'b1;
            end else if (!pending_v) begin
                pending_data <= push_data;
                pending_v    <= 1'b1;
            end
        end
    end

    assign drop = push && !pop && active_v && pending_v;

endmodule

// File: rtl/color_batch_unpacker.sv
// Unpacks BATCH_SIZE-colour words into a byte-wide valid/ready stream, byte 0
// first, with one pending batch of slack and overrun statistics.
module color_batch_unpacker
    import color_batch_pkg::*;
#(
    parameter int unsigned BATCH_SIZE = DEFAULT_BATCH_SIZE,
    parameter int unsigned DROP_CNT_W = 8
) (
    input  logic                           I_rgb_clk,
    input  logic                           I_rst_n,
    input  logic                           I_batch_ready,
    input  logic [batch_w(BATCH_SIZE)-1:0] I_batch_color,
    input  logic                           I_color_ready,
    input  logic                           I_overflow_clr,
    output logic [COLOR_W-1:0]             O_color,
    output logic                           O_color_valid,
    output logic                           O_color_last,
    output logic                           O_batch_done,
    output logic                           O_busy,
    output logic                           O_overflow,
    output logic [DROP_CNT_W-1:0]          O_drop_count
);

    localparam int unsigned       IDX_W    = $clog2(BATCH_SIZE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BATCH_SIZE - 1);

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [batch_w(BATCH_SIZE)-1:0] active_data;
    logic                           active_v, pending_v, drop;
    logic                           xfer, pop;

    assign xfer = O_color_valid && I_color_ready;
    assign pop  = xfer && O_color_last;

    batch_slot_queue #(
        .BATCH_SIZE (BATCH_SIZE)
    ) u_slots (
        .I_rgb_clk   (I_rgb_clk),
        .I_rst_n     (I_rst_n),
        .push        (I_batch_ready),
        .push_data   (I_batch_color),
        .pop         (pop),
        .active_data (active_data),
        .active_v    (active_v),
        .pending_v   (pending_v),
        .drop        (drop)
    );

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        O_color_valid = (state_q == STREAM);
        O_color_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                if (I_batch_ready) begin
                    state_d = STREAM;
                    idx_d   = '0;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        // A refill from pending or a same-cycle batch keeps streaming with no bubble
                        idx_d = '0;
                        if (!pending_v && !I_batch_ready)
                            state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign O_color = active_data[idx_q*COLOR_W +: COLOR_W];
    assign O_busy  = active_v || pending_v;

    always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_batch_done <= 1'b0;
            O_overflow   <= 1'b0;
            O_drop_count <= '0;
        end else begin
            O_batch_done <= pop;
            if (drop) begin
                O_overflow <= 1'b1;
                if (I_overflow_clr)
                    O_drop_count <= DROP_CNT_W'(1);
                else if (!(&O_drop_count))
                    O_drop_count <= O_drop_count + 1'b1;
            end else if (I_overflow_clr) begin
                O_overflow   <= 1'b0;
                O_drop_count <= '0;
            end
        end
    end

endmodule
